// File: rtl/neuron_mac_ctrl.sv
// neuron_mac_ctrl: dot-product sequencer time-sharing one external 16-bit multiplier
module neuron_mac_ctrl #(
    parameter int ADDR_W = 10,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] len,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr,
    input  logic [15:0]       x_data,
    input  logic [15:0]       w_data,
    output logic [15:0]       mul_a,
    output logic [15:0]       mul_b,
    input  logic [15:0]       mul_p,
    output logic [ACC_W-1:0]  acc_out,
    output logic              ovf
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
    state_t state, state_nx;
    logic [ADDR_W-1:0] len_q;
    logic data_vld, op_vld, accept, last_addr;
    logic [ACC_W:0] sum;
    assign accept    = (state == IDLE) && start;
    assign last_addr = addr == len_q - ADDR_W'(1);
    assign sum       = {1'b0, acc_out} + (ACC_W+1)'(mul_p);
    assign busy      = state != IDLE;
    assign done      = state == FIN;
    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end
    // next state: leave DRAIN once the final product sits on the multiplier with nothing behind it
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? ((len == '0) ? FIN : RUN) : IDLE;
            RUN:     state_nx = last_addr ? DRAIN : RUN;
            DRAIN:   state_nx = (op_vld && !data_vld) ? FIN : DRAIN;
            default: state_nx = IDLE;
        endcase
    end
    // address counter, operand stage and saturating accumulator, each stage tagged with a valid bit
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_q    <= '0;
            addr     <= '0;
            data_vld <= 1'b0;
            op_vld   <= 1'b0;
            mul_a    <= '0;
            mul_b    <= '0;
            acc_out  <= '0;
            ovf      <= 1'b0;
        end else begin
            data_vld <= state == RUN;
            op_vld   <= data_vld;
            if (data_vld) begin
                mul_a <= x_data;
                mul_b <= w_data;
            end
            if (accept) begin
                len_q   <= len;
                addr    <= '0;
                acc_out <= '0;
                ovf     <= 1'b0;
            end else begin
                if (state == RUN && !last_addr) addr <= addr + ADDR_W'(1);
                if (op_vld) begin
                    acc_out <= sum[ACC_W] ? '1 : sum[ACC_W-1:0];
                    ovf     <= ovf | sum[ACC_W];
                end
            end
        end
    end
endmodule

// File: tb/tb_neuron_mac_ctrl.sv
// tb_neuron_mac_ctrl: directed and random checks of neuron_mac_ctrl against a dot-product model
module tb_neuron_mac_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic start0 = 1'b0, start1 = 1'b0;
    logic [9:0] len0 = '0, len1 = '0;
    logic busy0, busy1, done0, done1, ovf0, ovf1;
    logic [9:0] addr0, addr1;
    logic [15:0] xd0, wd0, xd1, wd1, ma0, mb0, ma1, mb1, mp0, mp1;
    logic [31:0] acc0;
    logic [16:0] acc1;
    logic [15:0] xm [1024];
    logic [15:0] wm [1024];
    int passed = 0, total = 0;

    neuron_mac_ctrl #(.ADDR_W(10), .ACC_W(32)) dut0 (
        .clk(clk), .reset_n(reset_n), .start(start0), .len(len0), .busy(busy0), .done(done0),
        .addr(addr0), .x_data(xd0), .w_data(wd0), .mul_a(ma0), .mul_b(mb0), .mul_p(mp0),
        .acc_out(acc0), .ovf(ovf0));
    neuron_mac_ctrl #(.ADDR_W(10), .ACC_W(17)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start1), .len(len1), .busy(busy1), .done(done1),
        .addr(addr1), .x_data(xd1), .w_data(wd1), .mul_a(ma1), .mul_b(mb1), .mul_p(mp1),
        .acc_out(acc1), .ovf(ovf1));

    always #5 clk = ~clk;
    assign mp0 = 16'(32'(ma0) * 32'(mb0));
    assign mp1 = 16'(32'(ma1) * 32'(mb1));
    // one-cycle-latency activation and weight memories shared by both instances
    always @(posedge clk) begin
        xd0 <= xm[addr0];
        wd0 <= wm[addr0];
        xd1 <= xm[addr1];
        wd1 <= wm[addr1];
    end

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        total++;
        assert (o === e) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    endtask

    function automatic void model(input int l, input int accw, output logic [63:0] acc, output logic o);
        longint s = 0;
        longint mx = (longint'(1) << accw) - 1;
        logic [31:0] p;
        for (int i = 0; i < l; i++) begin
            p = 32'(xm[i]) * 32'(wm[i]);
            s += longint'(p[15:0]);
        end
        o = s > mx;
        acc = o ? 64'(mx) : 64'(s);
    endfunction

    task automatic run(input int inst, input int l, input bit inj);
        int fin = (l == 0) ? 1 : l + 3;
        logic [63:0] ea;
        logic eo;
        model(l, inst ? 17 : 32, ea, eo);
        if (inst != 0) begin start1 = 1'b1; len1 = 10'(l); end
        else begin start0 = 1'b1; len0 = 10'(l); end
        @(posedge clk); #1;
        start0 = 1'b0; start1 = 1'b0;
        for (int c = 1; c <= fin + 1; c++) begin
            chk($sformatf("busy i%0d L%0d c%0d", inst, l, c), inst ? busy1 : busy0, c <= fin);
            chk($sformatf("done i%0d L%0d c%0d", inst, l, c), inst ? done1 : done0, c == fin);
            if (c <= l) chk($sformatf("addr i%0d c%0d", inst, c), inst ? addr1 : addr0, c - 1);
            if (c >= 3 && c <= l + 2) begin
                chk($sformatf("mul_a i%0d c%0d", inst, c), inst ? ma1 : ma0, xm[c-3]);
                chk($sformatf("mul_b i%0d c%0d", inst, c), inst ? mb1 : mb0, wm[c-3]);
            end
            if (c >= fin) begin
                chk($sformatf("acc i%0d L%0d c%0d", inst, l, c), inst ? acc1 : acc0, ea);
                chk($sformatf("ovf i%0d L%0d c%0d", inst, l, c), inst ? ovf1 : ovf0, eo);
            end
            if (inj && c == 2) begin
                if (inst != 0) begin start1 = 1'b1; len1 = 10'd1; end
                else begin start0 = 1'b1; len0 = 10'd1; end
            end
            if (c <= fin) begin
                @(posedge clk); #1;
                start0 = 1'b0; start1 = 1'b0;
            end
        end
    endtask

    task automatic chk_reset0(input string tag);
        chk({tag, " busy"}, busy0, 0);
        chk({tag, " done"}, done0, 0);
        chk({tag, " addr"}, addr0, 0);
        chk({tag, " mul_a"}, ma0, 0);
        chk({tag, " mul_b"}, mb0, 0);
        chk({tag, " acc"}, acc0, 0);
        chk({tag, " ovf"}, ovf0, 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin xm[i] = '0; wm[i] = '0; end
        repeat (3) @(posedge clk);
        #1;
        chk_reset0("rst");
        chk("rst acc1", acc1, 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        xm[0] = 16'd3; wm[0] = 16'd5;
        run(0, 1, 1'b0);
        xm[0] = 16'd1; xm[1] = 16'd2; xm[2] = 16'd3; xm[3] = 16'd4;
        wm[0] = 16'd10; wm[1] = 16'd20; wm[2] = 16'd30; wm[3] = 16'd40;
        run(0, 4, 1'b0);
        chk("acc L4 literal", acc0, 300);
        run(0, 0, 1'b0);
        xm[0] = 16'h0100; xm[1] = 16'h0010; wm[0] = 16'h0100; wm[1] = 16'h0010;
        run(0, 2, 1'b0);
        chk("acc trunc literal", acc0, 32'h100);
        for (int i = 0; i < 3; i++) begin xm[i] = 16'h00FF; wm[i] = 16'h00FF; end
        run(1, 3, 1'b0);
        chk("sat literal", acc1, 17'h1FFFF);
        chk("sat ovf literal", ovf1, 1);
        xm[0] = 16'd2; wm[0] = 16'd3;
        run(1, 1, 1'b0);
        chk("after sat literal", acc1, 6);
        xm[0] = 16'd1; xm[1] = 16'd2; xm[2] = 16'd3; xm[3] = 16'd4;
        wm[0] = 16'd10; wm[1] = 16'd20; wm[2] = 16'd30; wm[3] = 16'd40;
        run(0, 4, 1'b1);
        start0 = 1'b1; len0 = 10'd4;
        @(posedge clk); #1;
        start0 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk_reset0("midrun");
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("post-rst done c%0d", c), done0, 0);
            chk($sformatf("post-rst busy c%0d", c), busy0, 0);
            @(posedge clk); #1;
        end
        xm[0] = 16'd7; wm[0] = 16'd7;
        run(0, 1, 1'b0);
        chk("acc 7x7 literal", acc0, 49);
        for (int r = 0; r < 12; r++) begin
            int inst = r % 2;
            int l = inst ? int'($urandom_range(1, 5)) : int'($urandom_range(1, 40));
            for (int i = 0; i < l; i++) begin
                xm[i] = 16'($urandom);
                wm[i] = (inst != 0 && r % 4 == 1) ? 16'($urandom_range(0, 255)) : 16'($urandom);
            end
            run(inst, l, r % 3 == 0);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
